// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic MAC array.
// MAC_SATURATE_EN selects clamping instead of wrap when narrowing results.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FLUSH,
    DRAIN
  } sa_state_t;

  localparam int COUNT_W = 8;
  localparam int MAX_W   = 64;

  // Shift then narrow to dw bits (clamp or wrap); result is sign-extended.
  function automatic logic signed [MAX_W-1:0] narrow(
    input logic signed [MAX_W-1:0] acc,
    input int                      shift,
    input int                      dw
  );
    logic signed [MAX_W-1:0] s;
`ifdef MAC_SATURATE_EN
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
`endif
    s = acc >>> shift;
`ifdef MAC_SATURATE_EN
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`else
    s = s <<< (MAX_W - dw);
    s = s >>> (MAX_W - dw);
`endif
    return s;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell of the systolic grid.
// Pass-through a/b registers plus a wrapping accumulator.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 40
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_q,
  output logic signed [DW-1:0] b_q,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_x;

  assign prod   = a_in * b_in;
  assign prod_x = AW'(prod);

  // Shift operands onward and accumulate; clr restarts the sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else if (en) begin
      a_q <= a_in;
      b_q <= b_in;
      acc <= clr ? prod_x : acc + prod_x;
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary NxN signed MAC grid with row-wise result drain.
// MAC_SATURATE_EN: clamp results instead of two's-complement wrap.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] w_lanes,
  input  logic                                   w_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_lanes,
  input  logic                                   a_valid,
  output logic                                   beat_ready,
  output logic                                   busy,
  output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] res_row,
  output logic [7:0]                             res_idx,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic                                   err_misalign
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LAST_BEAT = 2 * N - 1;

  sa_state_t state_q, state_d;
  logic [COUNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [COUNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] row_q, row_d;
  logic err_q;

  logic beat, mis, adv, clr, flushing;

  logic signed [DW-1:0] a_edge [N];
  logic signed [DW-1:0] b_edge [N];
  logic signed [DW-1:0] a_q [N][N];
  logic signed [DW-1:0] b_q [N][N];
  logic signed [AW-1:0] acc [N][N];

  assign flushing   = (state_q == FLUSH);
  assign beat_ready = rstn &&
    ((state_q == IDLE) || (state_q == COMPUTE));
  assign busy       = (state_q != IDLE);
  assign res_valid  = (state_q == DRAIN);
  assign res_idx    = row_q;
  assign err_misalign = err_q;

  assign beat = w_valid && a_valid && beat_ready;
  assign mis  = (w_valid ^ a_valid) && beat_ready;
  assign adv  = beat || flushing;
  assign clr  = beat && (state_q == IDLE);

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_edge[i] = flushing ? '0 : a_lanes[i];
    assign b_edge[i] = flushing ? '0 : w_lanes[i];
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [DW-1:0] a_in;
      logic signed [DW-1:0] b_in;
      if (c == 0) begin : g_al
        assign a_in = a_edge[r];
      end else begin : g_ai
        assign a_in = a_q[r][c-1];
      end
      if (r == 0) begin : g_bt
        assign b_in = b_edge[c];
      end else begin : g_bi
        assign b_in = b_q[r-1][c];
      end
      systolic_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk (clk),
        .rstn(rstn),
        .en  (adv),
        .clr (clr),
        .a_in(a_in),
        .b_in(b_in),
        .a_q (a_q[r][c]),
        .b_q (b_q[r][c]),
        .acc (acc[r][c])
      );
    end
  end

  // Present the selected accumulator row, narrowed, while draining.
  always_comb begin
    res_row = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < N; c++) begin
        res_row[c] = DW'(narrow(
          MAX_W'(acc[row_q[IW-1:0]][c]), OUT_SHIFT, DW));
      end
    end
  end

  // Sequencer next state: beat count, flush length, drain row.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          state_d    = COMPUTE;
          beat_cnt_d = COUNT_W'(1);
        end
      end
      COMPUTE: begin
        if (beat) begin
          if (beat_cnt_q == COUNT_W'(LAST_BEAT - 1)) begin
            state_d     = FLUSH;
            beat_cnt_d  = '0;
            flush_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + COUNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == COUNT_W'(N - 2)) begin
          state_d     = DRAIN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + COUNT_W'(1);
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (row_q == 8'(N - 1)) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers and sticky misalignment flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      if (mis) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed self-checking bench for systolic_mac_array (N=2).
// Expected C values are hand-computed from the A and W matrices.
module tb_systolic_mac_array;

  localparam int N  = 2;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0][DW-1:0] w_lanes = '0;
  logic [N-1:0][DW-1:0] a_lanes = '0;
  logic [N-1:0][DW-1:0] res_row;
  logic w_valid = 1'b0;
  logic a_valid = 1'b0;
  logic res_ready = 1'b0;
  logic beat_ready, busy, res_valid, err_misalign;
  logic [7:0] res_idx;

  int checks = 0;
  int errors = 0;

  logic [N-1:0][DW-1:0] wv [3];
  logic [N-1:0][DW-1:0] av [3];
  int exp_c [N][N];

  always #5 clk = ~clk;

  systolic_mac_array #(
    .MATRIX_SIZE(N),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (40),
    .OUT_SHIFT  (0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .w_lanes     (w_lanes),
    .w_valid     (w_valid),
    .a_lanes     (a_lanes),
    .a_valid     (a_valid),
    .beat_ready  (beat_ready),
    .busy        (busy),
    .res_row     (res_row),
    .res_idx     (res_idx),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .err_misalign(err_misalign)
  );

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0][DW-1:0] lanes(input int l0,
                                                 input int l1);
    logic [N-1:0][DW-1:0] v;
    v[0] = DW'(l0);
    v[1] = DW'(l1);
    return v;
  endfunction

  task automatic set_job(input int j);
    case (j)
      0: begin
        wv[0] = lanes(5, 0); wv[1] = lanes(7, 6); wv[2] = lanes(0, 8);
        av[0] = lanes(1, 0); av[1] = lanes(2, 3); av[2] = lanes(0, 4);
        exp_c[0][0] = 19; exp_c[0][1] = 22;
        exp_c[1][0] = 43; exp_c[1][1] = 50;
      end
      1: begin
        wv[0] = lanes(2, 0); wv[1] = lanes(0, 0); wv[2] = lanes(0, 2);
        av[0] = lanes(1, 0); av[1] = lanes(0, 0); av[2] = lanes(0, 1);
        exp_c[0][0] = 2; exp_c[0][1] = 0;
        exp_c[1][0] = 0; exp_c[1][1] = 2;
      end
      default: begin
        wv[0] = lanes(32767, 0); wv[1] = lanes(32767, 0);
        wv[2] = lanes(0, 0);
        av[0] = lanes(32767, 0); av[1] = lanes(32767, 0);
        av[2] = lanes(0, 0);
`ifdef MAC_SATURATE_EN
        exp_c[0][0] = 32767;
`else
        exp_c[0][0] = 2;
`endif
        exp_c[0][1] = 0;
        exp_c[1][0] = 0; exp_c[1][1] = 0;
      end
    endcase
  endtask

  task automatic send_beat(input int k);
    w_lanes = wv[k];
    a_lanes = av[k];
    w_valid = 1'b1;
    a_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    a_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap, input bit mis);
    send_beat(0);
    for (int i = 0; i < gap; i++) tick();
    if (mis) begin
      w_valid = 1'b1;
      tick();
      w_valid = 1'b0;
    end
    send_beat(1);
    send_beat(2);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic drain(input string tag, input int hold);
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_v"}, res_valid, 1);
      check({tag, "_hold_idx"}, res_idx, 0);
      check({tag, "_hold_c0"}, $signed(res_row[0]), exp_c[0][0]);
      check({tag, "_hold_c1"}, $signed(res_row[1]), exp_c[0][1]);
      tick();
    end
    for (int r = 0; r < N; r++) begin
      check({tag, "_v"}, res_valid, 1);
      check({tag, "_idx"}, res_idx, r);
      for (int c = 0; c < N; c++)
        check({tag, "_elem"}, $signed(res_row[c]), exp_c[r][c]);
      res_ready = 1'b1;
      if (r == N - 1) begin
        w_lanes = wv[0];
        a_lanes = av[0];
        w_valid = 1'b1;
        a_valid = 1'b1;
      end
      tick();
      res_ready = 1'b0;
      w_valid = 1'b0;
      a_valid = 1'b0;
    end
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_v"}, res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_ready", beat_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_err", err_misalign, 0);
    check("rst_idx", res_idx, 0);
    check("rst_row", res_row, 0);
    rstn = 1'b1;
    tick();
    check("idle_ready", beat_ready, 1);

    set_job(0);
    send_stream(0, 1'b0);
    check("lat_pre", res_valid, 0);
    check("flush_busy", busy, 1);
    check("flush_ready", beat_ready, 0);
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    check("lat", res_valid, 1);
    check("flush_noerr", err_misalign, 0);
    drain("job0", 0);

    send_stream(3, 1'b0);
    check("gap_pre", res_valid, 0);
    tick();
    check("gap_lat", res_valid, 1);
    drain("gap", 0);

    send_stream(0, 1'b0);
    wait_valid("hold_wait");
    drain("hold", 4);

    set_job(1);
    send_stream(0, 1'b0);
    wait_valid("job2_wait");
    drain("job2", 0);

    set_job(0);
    send_stream(0, 1'b1);
    check("mis_err", err_misalign, 1);
    wait_valid("mis_wait");
    drain("mis", 0);
    check("mis_sticky", err_misalign, 1);

    set_job(2);
    send_stream(0, 1'b0);
    wait_valid("sat_wait");
    drain("sat", 0);

    set_job(0);
    send_stream(0, 1'b0);
    check("mid_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("mid_busy0", busy, 0);
    check("mid_valid0", res_valid, 0);
    check("mid_ready0", beat_ready, 0);
    check("mid_err0", err_misalign, 0);
    check("mid_idx0", res_idx, 0);
    check("mid_row0", res_row, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_ready", beat_ready, 1);
    send_stream(0, 1'b0);
    wait_valid("post_wait");
    drain("post", 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
